alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Front end that feeds the registered ALU: accepts one RV32I OP/OP-IMM instruction per handshake,
//  decodes it, reads the 32x32 register file, drives ALU operands and sel, captures the ALU result
//  one cycle later and writes it back to rd. Sits between instruction fetch and the ALU.
//  Non-pipelined: one instruction in flight, 3 cycles per instruction.
// PARAMETERS
//  XLEN     32  datapath width (only 32 supported)
//  NREGS    32  register count (x0 hardwired to zero)
// PORTS
//  clk          in   1   single clock, all flops on posedge
//  rst_n        in   1   asynchronous active-low reset
//  instr_valid  in   1   instr holds a valid instruction
//  instr_ready  out  1   block can accept (= state==IDLE)
//  instr        in   32  instruction word
//  alu_rs1      out  32  ALU operand A (registered)
//  alu_rs2      out  32  ALU operand B (registered)
//  alu_sel      out  4   ALU op select (registered)
//  alu_result   in   32  ALU registered output
//  wb_valid     out  1   1-cycle pulse: writeback cycle
//  wb_rd        out  5   destination register of writeback
//  wb_data      out  32  writeback data
//  illegal      out  1   1-cycle pulse: rejected instruction
//  dbg_addr     in   5   debug read address
//  dbg_data     out  32  combinational regfile read (x0 reads 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; alu_rs1/alu_rs2/alu_sel/wb_rd/wb_data=0; wb_valid=illegal=0;
//   all registers x1..x31 = 0; instr_ready=1. Reset mid-instruction drops it, no regfile write.
//  FSM: IDLE -> (instr_valid & legal) -> ISSUE -> WB -> IDLE. Illegal accept: stays IDLE, illegal=1
//   for the following cycle, no operand/regfile change. instr_valid ignored in ISSUE/WB.
//  Cycle 0 (IDLE, valid&ready): decode, read rs1/rs2 from regfile, load alu_* regs, latch rd.
//  Cycle 1 (ISSUE): alu_* stable; ALU samples at end of cycle.
//  Cycle 2 (WB): wb_valid=1, wb_rd=rd, wb_data=alu_result (SLT/SLTU: {31'b0,alu_result[0]});
//   regfile[rd] written at end of cycle unless rd==0. Next accept earliest cycle 3.
//  No forwarding needed: operand read only in IDLE, after previous write completed.
//  sel map: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, AND 0100, OR 0101, XOR 0110, SLL 0111,
//   SRL 1000, SRA 1001.
//  OP (0110011): funct7 0000000 -> f3 000 ADD,001 SLL,010 SLT,011 SLTU,100 XOR,101 SRL,110 OR,
//   111 AND; funct7 0100000 -> f3 000 SUB, 101 SRA; anything else illegal. alu_rs2 = x[rs2].
//  OP-IMM (0010011): alu_rs2 = sign-extended instr[31:20]; f3 000 ADDI,010 SLTI,011 SLTIU,100 XORI,
//   110 ORI,111 ANDI; 001 SLLI needs instr[31:25]=0; 101 SRLI (0000000)/SRAI (0100000);
//   shifts drive alu_rs2={27'b0,instr[24:20]}; other imm[11:5] for shifts illegal.
//  All other opcodes illegal. Arithmetic wraps modulo 2^32 (done in ALU).
//  wb_valid pulses even for rd=0; write suppressed, x0 always reads 0.
// TESTING (bench models ALU as posedge-registered)
//  T1 reset, ADDI x1,x0,5 (0x00500093) -> accept c0, wb_valid c2, wb_rd=1, wb_data=5; dbg x1=5.
//  T2 ADDI x2,x0,-3 (0xFFD00113), SUB x3,x1,x2 (0x402081B3) -> sel=0001, rs1=5,
//     rs2=0xFFFFFFFD, x3=8.
//  T3 SRAI x4,x2,1 (0x40115213) -> sel=1001, alu_rs2=1, x4=0xFFFFFFFE.
//  T4 ECALL (0x00000073) -> illegal=1 one cycle, no wb_valid, instr_ready stays 1, regs unchanged.
//  T5 ADDI x0,x0,7 (0x00700013) -> wb_valid=1, wb_rd=0; dbg x0=0.
//  T6 hold instr_valid in ISSUE/WB -> instr_ready=0, no second accept; rst_n low in WB -> no write,
//     all outputs reset, instr_ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a registered ALU. It accepts one RV32I OP/OP-IMM instruction,
// reads its operands from the register file, drives the ALU for one cycle and writes the result
// back. One instruction is in flight at a time and each one takes three cycles.
module alu_issue_ctrl #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   output logic [3:0]      alu_sel,
   input  logic [XLEN-1:0] alu_result,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;

   localparam logic [3:0] SelAdd  = 4'b0000;
   localparam logic [3:0] SelSub  = 4'b0001;
   localparam logic [3:0] SelSlt  = 4'b0010;
   localparam logic [3:0] SelSltu = 4'b0011;
   localparam logic [3:0] SelAnd  = 4'b0100;
   localparam logic [3:0] SelOr   = 4'b0101;
   localparam logic [3:0] SelXor  = 4'b0110;
   localparam logic [3:0] SelSll  = 4'b0111;
   localparam logic [3:0] SelSrl  = 4'b1000;
   localparam logic [3:0] SelSra  = 4'b1001;

   state_e          state_q, state_d;
   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] alu_rs1_q, alu_rs2_q;
   logic [3:0]      alu_sel_q;
   logic [4:0]      rd_q;
   logic            illegal_q;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [4:0]      rs1_idx, rs2_idx;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            dec_legal;
   logic [3:0]      dec_sel;
   logic [XLEN-1:0] dec_b;
   logic            accept;
   logic            is_slt;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];

   // x0 is never written, but the explicit zero keeps the read independent of that.
   assign rs1_val  = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
   assign rs2_val  = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

   // Decode the offered instruction into legality, ALU select and operand B.
   always_comb begin
      dec_legal = 1'b0;
      dec_sel   = SelAdd;
      dec_b     = rs2_val;
      case (opcode)
         OpcOp: begin
            dec_legal = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: dec_sel = SelAdd;
               10'b0000000_001: dec_sel = SelSll;
               10'b0000000_010: dec_sel = SelSlt;
               10'b0000000_011: dec_sel = SelSltu;
               10'b0000000_100: dec_sel = SelXor;
               10'b0000000_101: dec_sel = SelSrl;
               10'b0000000_110: dec_sel = SelOr;
               10'b0000000_111: dec_sel = SelAnd;
               10'b0100000_000: dec_sel = SelSub;
               10'b0100000_101: dec_sel = SelSra;
               default:         dec_legal = 1'b0;
            endcase
         end
         OpcOpImm: begin
            dec_legal = 1'b1;
            dec_b     = {{(XLEN-12){instr[31]}}, instr[31:20]};
            case (funct3)
               3'b000: dec_sel = SelAdd;
               3'b010: dec_sel = SelSlt;
               3'b011: dec_sel = SelSltu;
               3'b100: dec_sel = SelXor;
               3'b110: dec_sel = SelOr;
               3'b111: dec_sel = SelAnd;
               3'b001: begin
                  dec_sel   = SelSll;
                  dec_b     = {{(XLEN-5){1'b0}}, instr[24:20]};
                  dec_legal = (funct7 == 7'b0000000);
               end
               default: begin
                  // 3'b101: SRLI / SRAI distinguished by imm[11:5]
                  dec_b     = {{(XLEN-5){1'b0}}, instr[24:20]};
                  dec_sel   = funct7[5] ? SelSra : SelSrl;
                  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               end
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   assign accept = (state_q == StIdle) && instr_valid && dec_legal;

   // Next-state logic: a legal accept walks through ISSUE and WB back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StIssue;
         StIssue: state_d = StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Operand/select registers load only on accept; illegal is a one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_rs1_q <= '0;
         alu_rs2_q <= '0;
         alu_sel_q <= SelAdd;
         rd_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= (state_q == StIdle) && instr_valid && !dec_legal;
         if (accept) begin
            alu_rs1_q <= rs1_val;
            alu_rs2_q <= dec_b;
            alu_sel_q <= dec_sel;
            rd_q      <= instr[11:7];
         end
      end
   end

   // Register file write at the end of the WB cycle; x0 stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if ((state_q == StWb) && (rd_q != 5'd0)) begin
         rf_q[rd_q] <= wb_data;
      end
   end

   // Compare results carry only bit 0 of the ALU output.
   assign is_slt      = (alu_sel_q == SelSlt) || (alu_sel_q == SelSltu);
   assign instr_ready = (state_q == StIdle);
   assign wb_valid    = (state_q == StWb);
   assign wb_rd       = wb_valid ? rd_q : '0;
   assign wb_data     = !wb_valid ? '0 :
                        is_slt    ? {{(XLEN-1){1'b0}}, alu_result[0]} : alu_result;
   assign alu_rs1     = alu_rs1_q;
   assign alu_rs2     = alu_rs2_q;
   assign alu_sel     = alu_sel_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a registered ALU stand-in, an architectural model of the register
// file and instruction timing, a per-cycle compare process and directed literal checks.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = 32'h0;
   logic [31:0] alu_rs1, alu_rs2, alu_result = 32'h0;
   logic [3:0]  alu_sel;
   logic        wb_valid, illegal;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_sel(alu_sel),
      .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [31:0] sem(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (s)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return {31'b0, sa < sb};
         4'd3: return {31'b0, a < b};
         4'd4: return a & b;
         4'd5: return a | b;
         4'd6: return a ^ b;
         4'd7: return a << b[4:0];
         4'd8: return a >> b[4:0];
         4'd9: return sa >>> b[4:0];
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // ALU stand-in: compares return junk in the upper bits so masking is exercised.
   always @(posedge clk)
      alu_result <= (alu_sel == 4'd2 || alu_sel == 4'd3) ? (32'hA5A5_A5A4 | sem(alu_sel, alu_rs1, alu_rs2))
                                                         : sem(alu_sel, alu_rs1, alu_rs2);

   function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   // ---------------- architectural model ----------------
   logic [31:0] m_rf [32];
   int          m_phase = 0;   // 0 idle, 1 operands presented, 2 writeback
   bit          m_ill = 0;
   logic [3:0]  m_sel;
   logic [31:0] m_a, m_b, m_res;
   logic [4:0]  m_rd;

   initial for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;

   task automatic model_decode(input logic [31:0] w, output bit ok, output logic [3:0] sel,
                               output logic [31:0] b);
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = w[31:25];
      f3 = w[14:12];
      ok = 1'b0; sel = 4'd0; b = 32'h0;
      if (w[6:0] == 7'b0110011) begin
         b = m_rf[w[24:20]];
         if (f7 == 7'h00) begin
            ok = 1'b1;
            case (f3)
               3'd0: sel = 4'd0; 3'd1: sel = 4'd7; 3'd2: sel = 4'd2; 3'd3: sel = 4'd3;
               3'd4: sel = 4'd6; 3'd5: sel = 4'd8; 3'd6: sel = 4'd5; default: sel = 4'd4;
            endcase
         end else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; sel = 4'd1; end
         else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; sel = 4'd9; end
      end else if (w[6:0] == 7'b0010011) begin
         b = {{20{w[31]}}, w[31:20]};
         ok = 1'b1;
         case (f3)
            3'd0: sel = 4'd0; 3'd2: sel = 4'd2; 3'd3: sel = 4'd3;
            3'd4: sel = 4'd6; 3'd6: sel = 4'd5; 3'd7: sel = 4'd4;
            3'd1: begin sel = 4'd7; b = {27'b0, w[24:20]}; ok = (f7 == 7'h00); end
            default: begin
               b = {27'b0, w[24:20]};
               sel = (f7 == 7'h20) ? 4'd9 : 4'd8;
               ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
         endcase
      end
   endtask

   initial begin
      bit          ok;
      logic [3:0]  s;
      logic [31:0] b;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0;
            m_ill   = 1'b0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
         end else begin
            m_ill = 1'b0;
            if (m_phase == 2) begin
               if (m_rd != 5'd0) m_rf[m_rd] = m_res;
               m_phase = 0;
            end else if (m_phase == 1) begin
               m_phase = 2;
            end else if (instr_valid) begin
               model_decode(instr, ok, s, b);
               if (ok) begin
                  m_sel = s; m_a = m_rf[instr[19:15]]; m_b = b; m_rd = instr[11:7];
                  m_res = sem(s, m_a, m_b);
                  m_phase = 1;
               end else begin
                  m_ill = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("ready", {31'b0, instr_ready}, {31'b0, m_phase == 0});
         chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
         chk("wb_valid", {31'b0, wb_valid}, {31'b0, m_phase == 2});
         if (m_phase != 0) begin
            chk("alu_sel", {28'b0, alu_sel}, {28'b0, m_sel});
            chk("alu_rs1", alu_rs1, m_a);
            chk("alu_rs2", alu_rs2, m_b);
         end
         if (m_phase == 2) begin
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, m_rd});
            chk("wb_data", wb_data, m_res);
         end
         chk("dbg_data", dbg_data, m_rf[dbg_addr]);
      end
   end

   // ---------------- directed stimulus ----------------
   logic [3:0]  c_sel;
   logic [31:0] c_a, c_b, c_wd, rd_val;
   logic        c_ill, c_rdy, c_wbv;
   logic [4:0]  c_rd;

   // Offer one instruction for one cycle; capture outputs at the two following cycles.
   task automatic issue(input logic [31:0] w);
      @(posedge clk); #1;
      instr_valid = 1'b1; instr = w;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      c_sel = alu_sel; c_a = alu_rs1; c_b = alu_rs2; c_ill = illegal; c_rdy = instr_ready;
      @(posedge clk); #1;
      c_wbv = wb_valid; c_rd = wb_rd; c_wd = wb_data;
      @(posedge clk); #1;
   endtask

   task automatic peek(input logic [4:0] a);
      dbg_addr = a;
      #1 rd_val = dbg_data;
   endtask

   typedef struct {
      logic [31:0] w;
      bit          legal;
      logic [31:0] res;
   } vec_t;

   vec_t vecs [23];

   initial begin
      vecs[0]  = '{rt(7'h00, 5'd1, 5'd2, 3'd2, 5'd5),  1, 32'h0000_0001};  // SLT
      vecs[1]  = '{rt(7'h00, 5'd1, 5'd2, 3'd3, 5'd6),  1, 32'h0000_0000};  // SLTU
      vecs[2]  = '{it(12'hFFE, 5'd2, 3'd2, 5'd7),      1, 32'h0000_0001};  // SLTI
      vecs[3]  = '{it(12'hFFF, 5'd1, 3'd3, 5'd8),      1, 32'h0000_0001};  // SLTIU
      vecs[4]  = '{rt(7'h00, 5'd1, 5'd2, 3'd7, 5'd9),  1, 32'h0000_0005};  // AND
      vecs[5]  = '{rt(7'h00, 5'd1, 5'd2, 3'd6, 5'd10), 1, 32'hFFFF_FFFD};  // OR
      vecs[6]  = '{rt(7'h00, 5'd1, 5'd2, 3'd4, 5'd11), 1, 32'hFFFF_FFF8};  // XOR
      vecs[7]  = '{rt(7'h00, 5'd1, 5'd1, 3'd1, 5'd12), 1, 32'h0000_00A0};  // SLL
      vecs[8]  = '{rt(7'h00, 5'd1, 5'd2, 3'd5, 5'd13), 1, 32'h07FF_FFFF};  // SRL
      vecs[9]  = '{rt(7'h20, 5'd1, 5'd2, 3'd5, 5'd14), 1, 32'hFFFF_FFFF};  // SRA
      vecs[10] = '{it(12'h01F, 5'd1, 3'd1, 5'd15),     1, 32'h8000_0000};  // SLLI 31
      vecs[11] = '{it(12'h004, 5'd2, 3'd5, 5'd16),     1, 32'h0FFF_FFFF};  // SRLI 4
      vecs[12] = '{rt(7'h00, 5'd2, 5'd1, 3'd0, 5'd17), 1, 32'h0000_0002};  // ADD
      vecs[13] = '{it(12'h7FF, 5'd1, 3'd4, 5'd18),     1, 32'h0000_07FA};  // XORI
      vecs[14] = '{it(12'hF00, 5'd0, 3'd6, 5'd19),     1, 32'hFFFF_FF00};  // ORI
      vecs[15] = '{it(12'h0F0, 5'd2, 3'd7, 5'd20),     1, 32'h0000_00F0};  // ANDI
      vecs[16] = '{rt(7'h00, 5'd16, 5'd2, 3'd0, 5'd21), 1, 32'h0FFF_FFFC}; // ADD wraps
      vecs[17] = '{it(12'h021, 5'd1, 3'd1, 5'd22),     0, 32'h0};          // SLLI bad imm
      vecs[18] = '{rt(7'h01, 5'd1, 5'd1, 3'd0, 5'd22), 0, 32'h0};          // MUL
      vecs[19] = '{rt(7'h20, 5'd1, 5'd1, 3'd1, 5'd22), 0, 32'h0};          // f7=0100000 f3=001
      vecs[20] = '{32'h0000_A083,                      0, 32'h0};          // LW
      vecs[21] = '{it(12'h421, 5'd2, 3'd5, 5'd22),     0, 32'h0};          // SRAI bad imm
      vecs[22] = '{it(12'h41F, 5'd2, 3'd5, 5'd23),     1, 32'hFFFF_FFFF};  // SRAI 31
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, instr_ready}, 32'h1);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("rst_illegal", {31'b0, illegal}, 32'h0);
      chk("rst_alu_rs1", alu_rs1, 32'h0);
      chk("rst_alu_rs2", alu_rs2, 32'h0);
      chk("rst_alu_sel", {28'b0, alu_sel}, 32'h0);
      chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      rst_n = 1'b1;

      // T1 ADDI x1,x0,5
      issue(32'h0050_0093);
      chk("t1_wb_valid", {31'b0, c_wbv}, 32'h1);
      chk("t1_wb_rd", {27'b0, c_rd}, 32'h1);
      chk("t1_wb_data", c_wd, 32'h5);
      peek(5'd1); chk("t1_x1", rd_val, 32'h5);

      // T2 ADDI x2,x0,-3 ; SUB x3,x1,x2
      issue(32'hFFD0_0113);
      peek(5'd2); chk("t2_x2", rd_val, 32'hFFFF_FFFD);
      issue(32'h4020_81B3);
      chk("t2_sel", {28'b0, c_sel}, 32'h1);
      chk("t2_rs1", c_a, 32'h5);
      chk("t2_rs2", c_b, 32'hFFFF_FFFD);
      peek(5'd3); chk("t2_x3", rd_val, 32'h8);

      // T3 SRAI x4,x2,1
      issue(32'h4011_5213);
      chk("t3_sel", {28'b0, c_sel}, 32'h9);
      chk("t3_rs2", c_b, 32'h1);
      peek(5'd4); chk("t3_x4", rd_val, 32'hFFFF_FFFE);

      // T4 ECALL is rejected
      issue(32'h0000_0073);
      chk("t4_illegal", {31'b0, c_ill}, 32'h1);
      chk("t4_ready", {31'b0, c_rdy}, 32'h1);
      chk("t4_no_wb", {31'b0, c_wbv}, 32'h0);
      peek(5'd1); chk("t4_x1", rd_val, 32'h5);

      // T5 ADDI x0,x0,7: writeback pulses, x0 stays zero
      issue(32'h0070_0013);
      chk("t5_wb_valid", {31'b0, c_wbv}, 32'h1);
      chk("t5_wb_rd", {27'b0, c_rd}, 32'h0);
      chk("t5_wb_data", c_wd, 32'h7);
      peek(5'd0); chk("t5_x0", rd_val, 32'h0);

      // Operation table
      foreach (vecs[i]) begin
         issue(vecs[i].w);
         chk($sformatf("vec%0d_illegal", i), {31'b0, c_ill}, {31'b0, !vecs[i].legal});
         chk($sformatf("vec%0d_wb_valid", i), {31'b0, c_wbv}, {31'b0, vecs[i].legal});
         if (vecs[i].legal) chk($sformatf("vec%0d_wb_data", i), c_wd, vecs[i].res);
      end
      peek(5'd22); chk("illegal_no_write", rd_val, 32'h0);

      // T6 valid held through ISSUE/WB: only one accept
      @(posedge clk); #1;
      instr_valid = 1'b1; instr = it(12'd9, 5'd0, 3'd0, 5'd5);
      @(posedge clk); #1;
      chk("t6_issue_ready", {31'b0, instr_ready}, 32'h0);
      @(posedge clk); #1;
      chk("t6_wb_ready", {31'b0, instr_ready}, 32'h0);
      chk("t6_wb_valid", {31'b0, wb_valid}, 32'h1);
      @(posedge clk); #1;
      chk("t6_idle_ready", {31'b0, instr_ready}, 32'h1);
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_no_second", {31'b0, wb_valid | ~instr_ready}, 32'h0);
      peek(5'd5); chk("t6_x5", rd_val, 32'h9);

      // T6 reset during WB: no write, outputs back to reset values
      instr_valid = 1'b1; instr = it(12'd11, 5'd0, 3'd0, 5'd6);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6r_in_wb", {31'b0, wb_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6r_ready", {31'b0, instr_ready}, 32'h1);
      chk("t6r_wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("t6r_wb_data", wb_data, 32'h0);
      chk("t6r_alu_sel", {28'b0, alu_sel}, 32'h0);
      chk("t6r_alu_rs1", alu_rs1, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      peek(5'd6); chk("t6r_x6", rd_val, 32'h0);
      peek(5'd1); chk("t6r_x1", rd_val, 32'h0);

      // Back to normal operation after reset
      issue(32'h0050_0093);
      chk("post_wb_data", c_wd, 32'h5);
      peek(5'd1); chk("post_x1", rd_val, 32'h5);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
